mem_arbiter: RTL and testbench

Sits directly downstream of the CPU pipeline's two memory device ports (port 1 = instruction cache, read-only; port 2 = data cache, read/write). Arbitrates both onto one single-ported synchronous memory. Sequences single-word and fixed-length burst accesses, and returns read data plus a one-cycle per-device acknowledge. Consumes exactly the pipeline's device_1/device_2 address/data/enable/write/burst/bank-select signals, and produces its devices_do_ack and mem_do inputs.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 49 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_e : arbiter FSM states (idle, issue, wait-for-data, acknowledge)
//   PORT_I  : index of the instruction-cache port (device 1)
//   PORT_D  : index of the data-cache port (device 2)
//   BE_ALL  : all byte lanes enabled
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StAck
    } state_e;

    localparam logic       PORT_I = 1'b0;
    localparam logic       PORT_D = 1'b1;
    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selection for the two device ports.
// Build option: MEM_ARB_FIXED_PRIO_EN -- when defined, the data port always wins
// a tie and no round-robin state is kept; otherwise ties alternate.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req          : per-port request, bit PORT_I = instruction port
//   i_update       : arbiter is in a grant cycle; round-robin state advances on ties
//   o_grant        : index of the port to grant
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = i_clk ^ i_reset ^ i_update;

    always_comb begin
        o_grant = i_req[PORT_D] ? PORT_D : PORT_I;
    end
`else
    // Port that won the most recent tie; single-port grants leave it alone.
    logic r_last_grant;

    always_comb begin
        if (i_req == 2'b11) begin
            o_grant = (r_last_grant == PORT_D) ? PORT_I : PORT_D;
        end else if (i_req[PORT_D]) begin
            o_grant = PORT_D;
        end else begin
            o_grant = PORT_I;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= PORT_D;
        end else if (i_update && (i_req == 2'b11)) begin
            r_last_grant <= o_grant;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the instruction-cache port (1, read-only) and the
// data-cache port (2, read/write) onto one single-ported synchronous memory,
// sequencing single-word and fixed-length burst accesses.
// Build option: MEM_ARB_FIXED_PRIO_EN (see mem_arb_pick) selects fixed data-port
// priority on ties instead of round-robin.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   device_1_mem_addr           : port-1 word address
//   device_2_mem_addr/_mem_di   : port-2 word address / write data
//   device_2_bank_select        : port-2 byte enables for writes
//   devices_burst_en/_mem_we/_mem_en : per-port burst, write and request (bit0 = port 1)
//   devices_do_ack              : per-port one-cycle acknowledge
//   mem_do                      : registered read data, valid in the ack cycle
//   mem_addr/_di/_be/_we/_en    : memory request signals
//   mem_rdata                   : memory read data, MEM_LATENCY cycles after mem_en
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned BURST_LEN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] device_1_mem_addr,
    input  logic [15:0] device_2_mem_addr,
    input  logic [31:0] device_2_mem_di,
    input  logic [3:0]  device_2_bank_select,
    input  logic [1:0]  devices_burst_en,
    input  logic [1:0]  devices_mem_we,
    input  logic [1:0]  devices_mem_en,
    output logic [1:0]  devices_do_ack,
    output logic [31:0] mem_do,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_di,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_en,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned    CW         = $clog2(MEM_LATENCY + 1);
    localparam int unsigned    BW         = $clog2(BURST_LEN);
    localparam logic [CW-1:0]  CNT_INIT   = CW'(MEM_LATENCY);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(1);
    localparam logic [BW-1:0]  BEATS_LAST = BW'(BURST_LEN - 1);

    state_e        r_state;
    state_e        w_state_next;
    logic          r_grant;
    logic [15:0]   r_addr;
    logic          r_we;
    logic          r_burst;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_beats;
    logic [31:0]   r_mem_do;

    logic          w_grant;
    logic          w_pick_update;
    logic          w_burst_more;
    logic          w_unused;

    // Port 1 is read-only, so its write-enable bit carries no information.
    assign w_unused      = devices_mem_we[PORT_I];
    assign w_pick_update = (r_state == StIdle);
    assign w_burst_more  = r_burst && (r_beats != BEATS_LAST);
    assign mem_do        = r_mem_do;

    mem_arb_pick u_pick (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_req    (devices_mem_en),
        .i_update (w_pick_update),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_state_next   = r_state;
        devices_do_ack = 2'b00;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_di         = '0;
        mem_be         = '0;
        unique case (r_state)
            StIdle: begin
                if (|devices_mem_en) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                mem_en   = 1'b1;
                mem_addr = r_addr;
                mem_be   = BE_ALL;
                if (r_grant == PORT_D) begin
                    mem_we = r_we;
                    // Write data is taken live so burst writes see the word
                    // the device presented after the previous ack.
                    mem_di = device_2_mem_di;
                    if (r_we) begin
                        mem_be = device_2_bank_select;
                    end
                end
                w_state_next = StWait;
            end
            StWait: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                devices_do_ack[r_grant] = 1'b1;
                // Never back to a grant decision here: a stale en in the ack
                // cycle cannot start a second access.
                w_state_next = w_burst_more ? StIssue : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_grant  <= PORT_I;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_burst  <= 1'b0;
            r_cnt    <= '0;
            r_beats  <= '0;
            r_mem_do <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (|devices_mem_en) begin
                        r_grant <= w_grant;
                        r_addr  <= (w_grant == PORT_D) ? device_2_mem_addr : device_1_mem_addr;
                        r_we    <= (w_grant == PORT_D) && devices_mem_we[PORT_D];
                        r_burst <= devices_burst_en[w_grant];
                    end
                end
                StIssue: begin
                    r_cnt <= CNT_INIT;
                end
                StWait: begin
                    if (r_cnt == CNT_LAST) begin
                        if (!r_we) begin
                            r_mem_do <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                StAck: begin
                    if (w_burst_more) begin
                        r_addr  <= r_addr + 16'd1;
                        r_beats <= r_beats + BW'(1);
                    end else begin
                        r_beats <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT with MEM_LATENCY=1
    logic [15:0] d1_addr, d2_addr, m_addr;
    logic [31:0] d2_di, m_do, m_di, m_rdata;
    logic [3:0]  d2_bs, m_be;
    logic [1:0]  burst, we, en, ack;
    logic        m_we, m_en;

    // DUT with MEM_LATENCY=3
    logic [15:0] e_addr1, m3_addr;
    logic [31:0] m3_do, m3_di, m3_rdata;
    logic [3:0]  m3_be;
    logic [1:0]  en3, ack3;
    logic        m3_we, m3_en;

    int n_err = 0;
    int n_chk = 0;

    mem_arbiter #(.MEM_LATENCY(1), .BURST_LEN(4)) dut (
        .clk(clk), .reset(reset),
        .device_1_mem_addr(d1_addr), .device_2_mem_addr(d2_addr),
        .device_2_mem_di(d2_di), .device_2_bank_select(d2_bs),
        .devices_burst_en(burst), .devices_mem_we(we), .devices_mem_en(en),
        .devices_do_ack(ack), .mem_do(m_do), .mem_addr(m_addr), .mem_di(m_di),
        .mem_be(m_be), .mem_we(m_we), .mem_en(m_en), .mem_rdata(m_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(3), .BURST_LEN(4)) dut3 (
        .clk(clk), .reset(reset),
        .device_1_mem_addr(e_addr1), .device_2_mem_addr(16'h0000),
        .device_2_mem_di(32'h0), .device_2_bank_select(4'h0),
        .devices_burst_en(2'b00), .devices_mem_we(2'b00), .devices_mem_en(en3),
        .devices_do_ack(ack3), .mem_do(m3_do), .mem_addr(m3_addr), .mem_di(m3_di),
        .mem_be(m3_be), .mem_we(m3_we), .mem_en(m3_en), .mem_rdata(m3_rdata)
    );

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a ^ 16'h5A5A};
    endfunction

    // Memory models: data is valid only in the cycle exactly MEM_LATENCY after
    // mem_en, garbage otherwise, so a mistimed capture is visible.
    always @(posedge clk) begin
        m_rdata <= (m_en && !m_we) ? rd_word(m_addr) : 32'hBAD0_0001;
    end

    logic        p0v, p1v;
    logic [15:0] p0a, p1a;
    always @(posedge clk) begin
        p0v      <= m3_en && !m3_we;
        p0a      <= m3_addr;
        p1v      <= p0v;
        p1a      <= p0a;
        m3_rdata <= p1v ? rd_word(p1a) : 32'hBAD0_0003;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the latency-1 DUT, starting from the grant (IDLE) cycle.
    task automatic xfer(input string tag, input logic [15:0] a, input logic exp_we,
                        input logic [3:0] exp_be, input logic [31:0] exp_di,
                        input logic [1:0] exp_ack, input logic [31:0] exp_do);
        tick();
        check({tag, "_iss_en"}, 32'(m_en), 32'd1);
        check({tag, "_iss_addr"}, 32'(m_addr), 32'(a));
        check({tag, "_iss_we"}, 32'(m_we), 32'(exp_we));
        check({tag, "_iss_be"}, 32'(m_be), 32'(exp_be));
        check({tag, "_iss_di"}, m_di, exp_di);
        check({tag, "_iss_ack"}, 32'(ack), 32'd0);
        tick();
        check({tag, "_wait_en"}, 32'({m_en, m_we}), 32'd0);
        check({tag, "_wait_ack"}, 32'(ack), 32'd0);
        tick();
        check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, "_do"}, m_do, exp_do);
    endtask

    logic        w1;
    logic [15:0] ba;

    initial begin
        reset = 1'b1;
        d1_addr = '0; d2_addr = '0; d2_di = '0; d2_bs = '0;
        burst = '0; we = '0; en = '0;
        e_addr1 = '0; en3 = '0;
        tick();
        tick();
        check("rst_ctl", {8'h0, m_addr, m_be, m_we, m_en, ack}, 32'h0);
        check("rst_di", m_di, 32'h0);
        check("rst_do", m_do, 32'h0);
        reset = 1'b0;
        tick();

        // 1: port-1 single read
        d1_addr = 16'h0010; en = 2'b01;
        xfer("t1", 16'h0010, 1'b0, 4'hF, 32'h0, 2'b01, 32'hDEADBEEF);
        en = 2'b00;
        tick();
        check("t1_idle_ack", 32'(ack), 32'd0);

        // 2: port-2 write with byte enables; mem_do must hold
        d2_addr = 16'h0040; d2_di = 32'h12345678; d2_bs = 4'b0011; we = 2'b10; en = 2'b10;
        xfer("t2", 16'h0040, 1'b1, 4'b0011, 32'h12345678, 2'b10, 32'hDEADBEEF);
        en = 2'b00; we = 2'b00; d2_di = '0;
        tick();

        // 3: two ties; round-robin gives P1 then P2 first (fixed: P2 both times)
        d1_addr = 16'h0100; d2_addr = 16'h0200; en = 2'b11;
        w1 = FIXED;
        xfer("t3a", w1 ? 16'h0200 : 16'h0100, 1'b0, 4'hF, 32'h0, w1 ? 2'b10 : 2'b01,
             rd_word(w1 ? 16'h0200 : 16'h0100));
        en = w1 ? 2'b01 : 2'b10;
        tick();
        xfer("t3b", w1 ? 16'h0100 : 16'h0200, 1'b0, 4'hF, 32'h0, w1 ? 2'b01 : 2'b10,
             rd_word(w1 ? 16'h0100 : 16'h0200));
        en = 2'b00;
        tick();
        en = 2'b11;
        xfer("t3c", 16'h0200, 1'b0, 4'hF, 32'h0, 2'b10, rd_word(16'h0200));
        en = 2'b01;
        tick();
        xfer("t3d", 16'h0100, 1'b0, 4'hF, 32'h0, 2'b01, rd_word(16'h0100));
        en = 2'b00;
        tick();

        // 4: port-1 burst across the address wrap; port 2 waits for the 4th ack
        d1_addr = 16'hFFFE; d2_addr = 16'h0300; burst = 2'b01; en = 2'b01;
        ba = 16'hFFFE;
        for (int b = 0; b < 4; b++) begin
            xfer($sformatf("t4b%0d", b), ba, 1'b0, 4'hF, 32'h0, 2'b01, rd_word(ba));
            ba = ba + 16'd1;
            en = 2'b11;
            burst = 2'b00;
        end
        en = 2'b10;
        tick();
        check("t4_idle", 32'({m_en, ack}), 32'd0);
        xfer("t4d", 16'h0300, 1'b0, 4'hF, 32'h0, 2'b10, rd_word(16'h0300));
        en = 2'b00;
        tick();

        // 5: reset during WAIT of a port-2 read
        d1_addr = 16'h0450; d2_addr = 16'h0400; en = 2'b11;
        w1 = FIXED;
        xfer("t5a", w1 ? 16'h0400 : 16'h0450, 1'b0, 4'hF, 32'h0, w1 ? 2'b10 : 2'b01,
             rd_word(w1 ? 16'h0400 : 16'h0450));
        en = w1 ? 2'b01 : 2'b10;
        tick();
        tick();
        check("t5_iss_en", 32'(m_en), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_ctl", {8'h0, m_addr, m_be, m_we, m_en, ack}, 32'h0);
        check("t5_rst_do", m_do, 32'h0);
        reset = 1'b0; en = 2'b00;
        tick();
        check("t5_noack1", 32'(ack), 32'd0);
        tick();
        check("t5_noack2", 32'(ack), 32'd0);
        d1_addr = 16'h0500; d2_addr = 16'h0600; en = 2'b11;
        xfer("t5b", w1 ? 16'h0600 : 16'h0500, 1'b0, 4'hF, 32'h0, w1 ? 2'b10 : 2'b01,
             rd_word(w1 ? 16'h0600 : 16'h0500));
        en = w1 ? 2'b01 : 2'b10;
        tick();
        xfer("t5c", w1 ? 16'h0500 : 16'h0600, 1'b0, 4'hF, 32'h0, w1 ? 2'b01 : 2'b10,
             rd_word(w1 ? 16'h0500 : 16'h0600));
        en = 2'b00;
        tick();

        // 6: MEM_LATENCY=3 read, ack 5 cycles after the IDLE cycle
        e_addr1 = 16'h0700; en3 = 2'b01;
        tick();
        check("t6_iss_en", 32'(m3_en), 32'd1);
        check("t6_iss_addr", 32'(m3_addr), 32'h0700);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t6_wait%0d", c), 32'({m3_en, ack3}), 32'd0);
        end
        tick();
        check("t6_ack", 32'(ack3), 32'd1);
        check("t6_do", m3_do, rd_word(16'h0700));
        en3 = 2'b00;
        tick();
        check("t6_post", 32'(ack3), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
